// File: rtl/game_pixel_gen.sv
// -----------------------------------------------------------------------------
// game_pixel_gen
//   Per-pixel colour source for a 1440x900 VGA timing stage. It holds the game
//   state (paddle, bouncing ball, score and an IDLE/PLAY/LOST FSM) and returns a
//   registered 4-bit R/G/B colour one clock after each curr_x/curr_y. Game state
//   only advances on a frame tick, taken from curr_y wrapping back to row 0.
//
// Ports
//   clk        in   1   pixel clock shared with the timing stage
//   rst        in   1   synchronous active-high reset
//   curr_x     in   11  current pixel column
//   curr_y     in   11  current pixel row
//   btn_left   in   1   asynchronous button, paddle left
//   btn_right  in   1   asynchronous button, paddle right
//   btn_fire   in   1   asynchronous button, launch ball from IDLE
//   rin/gin/bin out 4   registered pixel colour
//   score      out  8   paddle hits this game, saturating at 255
//   game_state out  2   00 IDLE, 01 PLAY, 10 LOST
// -----------------------------------------------------------------------------
module game_pixel_gen #(
  parameter int H_ACTIVE     = 1440,
  parameter int V_ACTIVE     = 900,
  parameter int BORDER       = 8,
  parameter int PADDLE_W     = 128,
  parameter int PADDLE_H     = 8,
  parameter int PADDLE_Y     = 868,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SIZE    = 16,
  parameter int BALL_SPEED   = 4,
  parameter int LOST_FRAMES  = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] curr_x,
  input  logic [10:0] curr_y,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  output logic [3:0]  rin,
  output logic [3:0]  gin,
  output logic [3:0]  bin,
  output logic [7:0]  score,
  output logic [1:0]  game_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_LOST = 2'b10
  } state_t;

  localparam int LC_W = $clog2(LOST_FRAMES);

  // All position arithmetic is 12-bit signed so that a step below zero is
  // visible as a negative value instead of wrapping.
  localparam logic signed [11:0] L_HA      = 12'(H_ACTIVE);
  localparam logic signed [11:0] L_VA      = 12'(V_ACTIVE);
  localparam logic signed [11:0] L_BORDER  = 12'(BORDER);
  localparam logic signed [11:0] L_PW      = 12'(PADDLE_W);
  localparam logic signed [11:0] L_PH      = 12'(PADDLE_H);
  localparam logic signed [11:0] L_PY      = 12'(PADDLE_Y);
  localparam logic signed [11:0] L_PSPD    = 12'(PADDLE_SPEED);
  localparam logic signed [11:0] L_BALL    = 12'(BALL_SIZE);
  localparam logic signed [11:0] L_BSPD    = 12'(BALL_SPEED);
  localparam logic signed [11:0] L_PX_MAX  = 12'(H_ACTIVE - PADDLE_W);
  localparam logic signed [11:0] L_PX0     = 12'((H_ACTIVE - PADDLE_W) / 2);
  localparam logic signed [11:0] L_BX0     = 12'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic signed [11:0] L_BY0     = 12'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic signed [11:0] L_BX_MAX  = 12'(H_ACTIVE - BORDER - BALL_SIZE);
  localparam logic signed [11:0] L_BY_HIT  = 12'(PADDLE_Y - BALL_SIZE);
  localparam logic [LC_W-1:0]    L_LC_LAST = LC_W'(LOST_FRAMES - 1);

  // Registered state
  logic              r_left_s1, r_left_s2;
  logic              r_right_s1, r_right_s2;
  logic              r_fire_s1, r_fire_s2;
  logic [10:0]       r_prev_y;
  state_t            r_state;
  logic signed [11:0] r_px, r_bx, r_by;
  logic              r_dir_r;   // 1: moving right
  logic              r_dir_u;   // 1: moving up
  logic [7:0]        r_score;
  logic [LC_W-1:0]   r_lost_cnt;
  logic [3:0]        r_rin, r_gin, r_bin;

  // Next-state values
  state_t            w_state_nxt;
  logic signed [11:0] w_px_mv, w_px_clamp, w_px_nxt;
  logic signed [11:0] w_bx_nxt, w_by_nxt, w_nx, w_ny;
  logic              w_dir_r_nxt, w_dir_u_nxt;
  logic [7:0]        w_score_nxt;
  logic [LC_W-1:0]   w_lost_cnt_nxt;
  logic              w_tick, w_overlap;

  // Pixel classification
  logic signed [11:0] w_x, w_y;
  logic              w_active, w_ball, w_paddle, w_border;
  logic [3:0]        w_rin, w_gin, w_bin;

  // Frame tick: first clock of row 0 after any other row.
  assign w_tick = (curr_y == 11'd0) && (r_prev_y != 11'd0);

  // Paddle candidate: step, then clamp into the visible range.
  always_comb begin
    w_px_mv = r_px;
    if (r_left_s2 && !r_right_s2) begin
      w_px_mv = r_px - L_PSPD;
    end else if (r_right_s2 && !r_left_s2) begin
      w_px_mv = r_px + L_PSPD;
    end
    w_px_clamp = w_px_mv;
    if (w_px_mv < 12'sd0) begin
      w_px_clamp = 12'sd0;
    end else if (w_px_mv > L_PX_MAX) begin
      w_px_clamp = L_PX_MAX;
    end
    w_px_nxt = w_tick ? w_px_clamp : r_px;
  end

  // Candidate ball step and paddle overlap against the paddle's new position.
  assign w_nx      = r_dir_r ? (r_bx + L_BSPD) : (r_bx - L_BSPD);
  assign w_ny      = r_dir_u ? (r_by - L_BSPD) : (r_by + L_BSPD);
  assign w_overlap = ((w_nx + L_BALL) > w_px_nxt) && (w_nx < (w_px_nxt + L_PW));

  // FSM next-state and ball update
  always_comb begin
    w_state_nxt    = r_state;
    w_bx_nxt       = r_bx;
    w_by_nxt       = r_by;
    w_dir_r_nxt    = r_dir_r;
    w_dir_u_nxt    = r_dir_u;
    w_score_nxt    = r_score;
    w_lost_cnt_nxt = r_lost_cnt;
    case (r_state)
      S_IDLE: begin
        w_bx_nxt    = L_BX0;
        w_by_nxt    = L_BY0;
        w_dir_r_nxt = 1'b1;
        w_dir_u_nxt = 1'b1;
        if (w_tick && r_fire_s2) begin
          w_state_nxt = S_PLAY;
          w_score_nxt = 8'd0;
        end
      end
      S_PLAY: begin
        if (w_tick) begin
          // Horizontal axis
          if (!r_dir_r && (w_nx < L_BORDER)) begin
            w_bx_nxt    = L_BORDER;
            w_dir_r_nxt = 1'b1;
          end else if (r_dir_r && ((w_nx + L_BALL) > (L_HA - L_BORDER))) begin
            w_bx_nxt    = L_BX_MAX;
            w_dir_r_nxt = 1'b0;
          end else begin
            w_bx_nxt = w_nx;
          end
          // Vertical axis; the paddle test only fires when the ball crosses
          // the paddle top from above on this step.
          if (r_dir_u) begin
            if (w_ny < L_BORDER) begin
              w_by_nxt    = L_BORDER;
              w_dir_u_nxt = 1'b0;
            end else begin
              w_by_nxt = w_ny;
            end
          end else if (((w_ny + L_BALL) >= L_PY) && ((r_by + L_BALL) <= L_PY) && w_overlap) begin
            w_by_nxt    = L_BY_HIT;
            w_dir_u_nxt = 1'b1;
            w_score_nxt = (r_score == 8'hFF) ? r_score : (r_score + 8'd1);
          end else if ((w_ny + L_BALL) >= L_VA) begin
            // Missed: the ball freezes where it was.
            w_state_nxt = S_LOST;
            w_bx_nxt    = r_bx;
            w_by_nxt    = r_by;
            w_dir_r_nxt = r_dir_r;
          end else begin
            w_by_nxt = w_ny;
          end
        end
      end
      S_LOST: begin
        if (w_tick) begin
          if (r_lost_cnt == L_LC_LAST) begin
            w_state_nxt    = S_IDLE;
            w_lost_cnt_nxt = '0;
            w_bx_nxt       = L_BX0;
            w_by_nxt       = L_BY0;
            w_dir_r_nxt    = 1'b1;
            w_dir_u_nxt    = 1'b1;
          end else begin
            w_lost_cnt_nxt = r_lost_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Game state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_left_s1  <= 1'b0;
      r_left_s2  <= 1'b0;
      r_right_s1 <= 1'b0;
      r_right_s2 <= 1'b0;
      r_fire_s1  <= 1'b0;
      r_fire_s2  <= 1'b0;
      r_prev_y   <= 11'd0;
      r_state    <= S_IDLE;
      r_px       <= L_PX0;
      r_bx       <= L_BX0;
      r_by       <= L_BY0;
      r_dir_r    <= 1'b1;
      r_dir_u    <= 1'b1;
      r_score    <= 8'd0;
      r_lost_cnt <= '0;
    end else begin
      r_left_s1  <= btn_left;
      r_left_s2  <= r_left_s1;
      r_right_s1 <= btn_right;
      r_right_s2 <= r_right_s1;
      r_fire_s1  <= btn_fire;
      r_fire_s2  <= r_fire_s1;
      r_prev_y   <= curr_y;
      r_state    <= w_state_nxt;
      r_px       <= w_px_nxt;
      r_bx       <= w_bx_nxt;
      r_by       <= w_by_nxt;
      r_dir_r    <= w_dir_r_nxt;
      r_dir_u    <= w_dir_u_nxt;
      r_score    <= w_score_nxt;
      r_lost_cnt <= w_lost_cnt_nxt;
    end
  end

  // Pixel classification, highest priority first: ball, paddle, border.
  assign w_x      = $signed({1'b0, curr_x});
  assign w_y      = $signed({1'b0, curr_y});
  assign w_active = (w_x < L_HA) && (w_y < L_VA);
  assign w_ball   = (w_x >= r_bx) && (w_x < (r_bx + L_BALL)) &&
                    (w_y >= r_by) && (w_y < (r_by + L_BALL));
  assign w_paddle = (w_x >= r_px) && (w_x < (r_px + L_PW)) &&
                    (w_y >= L_PY) && (w_y < (L_PY + L_PH));
  assign w_border = (w_x < L_BORDER) || (w_x >= (L_HA - L_BORDER)) || (w_y < L_BORDER);

  always_comb begin
    w_rin = 4'h0;
    w_gin = 4'h0;
    w_bin = 4'h0;
    if (w_active) begin
      if (w_ball) begin
        w_rin = 4'hF;
        w_gin = 4'hF;
        w_bin = 4'hF;
      end else if (w_paddle) begin
        w_gin = 4'hF;
        w_bin = 4'hF;
      end else if (w_border) begin
        w_rin = 4'h8;
        w_gin = 4'h8;
        w_bin = 4'h8;
      end else if (r_state == S_LOST) begin
        w_rin = 4'h8;
      end
    end
  end

  // Output colour register: one clock after curr_x/curr_y
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rin <= 4'h0;
      r_gin <= 4'h0;
      r_bin <= 4'h0;
    end else begin
      r_rin <= w_rin;
      r_gin <= w_gin;
      r_bin <= w_bin;
    end
  end

  assign rin        = r_rin;
  assign gin        = r_gin;
  assign bin        = r_bin;
  assign score      = r_score;
  assign game_state = r_state;

endmodule
